// File: rtl/gpio_input_capture_if.sv
// Peripheral bus bundle for gpio_input_capture: single-cycle read/write strobes with
// a 32-bit byte address and data. read_data is combinational and only meaningful while read=1.
interface gpio_input_capture_if;
  logic        read;
  logic        write;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;

  modport master (
    output read,
    output write,
    output address,
    output write_data,
    input  read_data
  );

  modport slave (
    input  read,
    input  write,
    input  address,
    input  write_data,
    output read_data
  );
endinterface

// File: rtl/gpio_input_capture.sv
// GPIO input capture: synchronises and debounces input pins, latches enabled edges into
// sticky W1C status bits and drives a level interrupt while any status bit is set.
module gpio_input_capture #(
  parameter int WIDTH           = 20,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  gpio_input_capture_if.slave  bus,
  input  logic [WIDTH-1:0]     pins,
  output logic                 irq
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    REG_LEVEL   = 2'd0,
    REG_STATUS  = 2'd1,
    REG_RISE_EN = 2'd2,
    REG_FALL_EN = 2'd3
  } reg_sel_e;

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] status_q, status_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;

  logic [WIDTH-1:0] rise, fall, event_set, status_clr;
  reg_sel_e         sel;
  logic [WIDTH-1:0] wdata;

  assign sel   = reg_sel_e'(bus.address[3:2]);
  assign wdata = bus.write_data[WIDTH-1:0];

  logic unused_bus_bits;
  assign unused_bus_bits = ^{bus.address[31:4], bus.address[1:0], bus.write_data};

  // Counter tracks consecutive cycles sync2 disagrees with stable; any agreement restarts it.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  assign rise      = stable_d & ~stable_q;
  assign fall      = ~stable_d & stable_q;
  assign event_set = (rise & rise_en_q) | (fall & fall_en_q);

  // New events are OR'd in after the clear so a same-edge event survives a W1C.
  always_comb begin
    status_clr = '0;
    rise_en_d  = rise_en_q;
    fall_en_d  = fall_en_q;
    if (bus.write) begin
      case (sel)
        REG_STATUS:  status_clr = wdata;
        REG_RISE_EN: rise_en_d  = wdata;
        REG_FALL_EN: fall_en_d  = wdata;
        default:     ;
      endcase
    end
    status_d = (status_q & ~status_clr) | event_set;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      stable_q  <= '0;
      status_q  <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q   <= pins;
      sync2_q   <= sync1_q;
      stable_q  <= stable_d;
      status_q  <= status_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign irq = |status_q;

  always_comb begin
    bus.read_data = '0;
    if (bus.read) begin
      case (sel)
        REG_LEVEL:   bus.read_data = 32'(stable_q);
        REG_STATUS:  bus.read_data = 32'(status_q);
        REG_RISE_EN: bus.read_data = 32'(rise_en_q);
        REG_FALL_EN: bus.read_data = 32'(fall_en_q);
        default:     bus.read_data = '0;
      endcase
    end
  end

endmodule
